mem_scoreboard: RTL and testbench
=================================

MEM_SCOREBOARD -- requirements
Module: mem_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning width of DUT data words.
REQ-002 SHALL have parameter ADDR_W, default 12, meaning DUT address width; model depth is 2^ADDR_W words.
REQ-003 SHALL have parameter RD_LAT, default 2, range 1..8, meaning cycles from read issue to valid DUT dout.
REQ-004 SHALL have parameter CNT_W, default 16, meaning width of the pass and fail counters.
REQ-005 SHALL have ports, in this order:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cen  in  1  DUT chip enable, active-low.
- wr  in  1  DUT write strobe.
- rd  in  1  DUT read strobe.
- addr  in  ADDR_W  DUT address.
- din  in  DATA_W  DUT write data.
- dout  in  DATA_W  DUT read data under check.
- busy  out  1  model clear in progress.
- pass_cnt  out  CNT_W  matched reads.
- fail_cnt  out  CNT_W  mismatched reads.
- err  out  1  sticky: any mismatch.
- err_addr  out  ADDR_W  address of first mismatch.
- err_exp  out  DATA_W  expected data of first mismatch.
- err_act  out  DATA_W  actual data of first mismatch.
- proto_err  out  1  sticky: illegal strobe combination.

Function
REQ-006 SHALL implement FSM with states CLEAR and RUN; CLEAR writes zero to model addresses 0..2^ADDR_W-1, one per cycle, then enters RUN.
REQ-007 SHALL assert busy exactly while in CLEAR (2^ADDR_W cycles after rst deasserts).
REQ-008 SHALL treat a cycle in RUN as a write when cen=0, wr=1, rd=0: model[addr] <= din at that edge.
REQ-009 SHALL treat a cycle in RUN as a read when cen=0, rd=1, wr=0: snapshot model[addr] as expected value at the issue cycle.
REQ-010 SHALL compare dout against the snapshot exactly RD_LAT cycles after issue, via a RD_LAT-deep valid/addr/expected pipeline.
REQ-011 SHALL accept back-to-back reads every cycle, with up to RD_LAT reads outstanding.
REQ-012 SHALL reflect all writes completed before a read's issue cycle in that read's snapshot, and no later writes.
REQ-013 SHALL on match increment pass_cnt; on mismatch increment fail_cnt and set err.
REQ-014 SHALL capture err_addr/err_exp/err_act only on the first mismatch; later mismatches leave them unchanged.
REQ-015 SHALL saturate pass_cnt and fail_cnt at 2^CNT_W-1.
REQ-016 SHALL treat cen=0 with rd=1 and wr=1 as illegal: set proto_err, no model update, no check issued.
REQ-017 SHALL treat cen=0 with rd=1 or wr=1 during CLEAR as illegal: set proto_err, transaction ignored.
REQ-018 SHALL ignore rd, wr, addr and din while cen=1.
REQ-019 SHALL wrap nothing: addr indexes the full 2^ADDR_W space, bank split is the caller's concern.
REQ-020 SHALL still complete in-flight compares whose issue preceded entry to CLEAR only when no reset intervenes (see REQ-022).

Reset
REQ-021 SHALL on rst=1 set busy=1, pass_cnt=0, fail_cnt=0, err=0, proto_err=0, err_addr=0, err_exp=0, err_act=0, clear-pointer=0, state=CLEAR.
REQ-022 SHALL on rst=1 discard all outstanding read-pipeline entries; rst mid-CLEAR restarts the sweep from address 0.

Structure
REQ-023 SHALL place FSM state enum and RD_LAT range limits in shared package mem_chk_pkg.
REQ-024 SHALL instantiate one sub-module mem_chk_model (single-port-write, async-read array, DATA_W x 2^ADDR_W) used by both CLEAR and write paths.

Verification
REQ-025 SHALL cover reset sweep: rst 1 cycle, ADDR_W=12 -> busy high exactly 4096 cycles, then read addr 0x7FF with dout=0 -> pass_cnt=1.
REQ-026 SHALL cover write/read: write 0xA5 to 0x403, read 0x403, DUT returns 0xA5 at issue+2 -> pass_cnt increments, err=0.
REQ-027 SHALL cover mismatch capture: expected 0x3C at 0xC10, dout=0x3D, then second mismatch at 0x001 -> fail_cnt=2, err_addr=0xC10, err_exp=0x3C, err_act=0x3D.
REQ-028 SHALL cover back-to-back: reads 0x000,0x001,0x002 on consecutive cycles, then write 0x001 same cycle as third read's compare -> all three compare against pre-write values.
REQ-029 SHALL cover protocol: cen=0, rd=wr=1 at 0x010 with din=0xFF -> proto_err=1, subsequent read 0x010 expects 0x00.
REQ-030 SHALL cover reset mid-operation: rst asserted with 2 reads outstanding and sweep half done -> no counter change, sweep restarts, busy 4096 cycles.

Source files
------------

// File: rtl/mem_chk_pkg.sv
// Shared definitions for the memory scoreboard slice.
//   chk_state_e : scoreboard FSM states (model clear sweep, normal checking).
//   RD_LAT_MIN/RD_LAT_MAX : legal range of the DUT read latency parameter.
package mem_chk_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } chk_state_e;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 8;

endpackage

// File: rtl/mem_chk_model.sv
// Reference memory model: one write port, one asynchronous read port.
// Ports:
//   clk   : clock, write on rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, combinational from raddr
module mem_chk_model #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/mem_scoreboard.sv
// Memory scoreboard: shadows writes to a DUT memory in a local model and
// checks every DUT read against the model contents at the read's issue cycle.
// Ports:
//   clk, rst   : clock; synchronous active-high reset
//   cen        : DUT chip enable, active-low
//   wr, rd     : DUT write / read strobes
//   addr, din  : DUT address and write data
//   dout       : DUT read data, valid RD_LAT cycles after the read issue
//   busy       : model clear sweep in progress
//   pass_cnt   : saturating count of matching reads
//   fail_cnt   : saturating count of mismatching reads
//   err        : sticky, any mismatch seen
//   err_addr/err_exp/err_act : address, expected and actual data of the
//                first mismatch
//   proto_err  : sticky, illegal strobe combination seen
module mem_scoreboard
    import mem_chk_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              wr,
    input  logic              rd,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    input  logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              err,
    output logic [ADDR_W-1:0] err_addr,
    output logic [DATA_W-1:0] err_exp,
    output logic [DATA_W-1:0] err_act,
    output logic              proto_err
);

    if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_range
        $error("mem_scoreboard: RD_LAT outside supported range");
    end

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    chk_state_e        state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic [CNT_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic [DATA_W-1:0] err_exp_q, err_exp_d;
    logic [DATA_W-1:0] err_act_q, err_act_d;
    logic              proto_err_q, proto_err_d;

    // Read pipeline: stage RD_LAT-1 lines up with the cycle the DUT drives dout.
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [ADDR_W-1:0] pipe_addr_q [RD_LAT];
    logic [ADDR_W-1:0] pipe_addr_d [RD_LAT];
    logic [DATA_W-1:0] pipe_exp_q  [RD_LAT];
    logic [DATA_W-1:0] pipe_exp_d  [RD_LAT];

    logic              in_clear;
    logic              run_wr;
    logic              run_rd;
    logic              proto_hit;
    logic              chk_vld;
    logic              chk_match;

    logic              mdl_we;
    logic [ADDR_W-1:0] mdl_waddr;
    logic [DATA_W-1:0] mdl_wdata;
    logic [DATA_W-1:0] mdl_rdata;

    assign in_clear  = (state_q == ST_CLEAR);
    assign run_wr    = !cen && wr && !rd && !in_clear;
    assign run_rd    = !cen && rd && !wr && !in_clear;
    assign proto_hit = !cen && ((rd && wr) || (in_clear && (rd || wr)));

    assign chk_vld   = pipe_vld_q[RD_LAT-1];
    assign chk_match = (dout == pipe_exp_q[RD_LAT-1]);

    // The clear sweep and DUT writes share the single model write port;
    // they never overlap because writes are illegal while clearing.
    always_comb begin
        mdl_we    = !rst && (in_clear || run_wr);
        mdl_waddr = in_clear ? clr_ptr_q : addr;
        mdl_wdata = in_clear ? '0 : din;
    end

    mem_chk_model #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_model (
        .clk   (clk),
        .we    (mdl_we),
        .waddr (mdl_waddr),
        .wdata (mdl_wdata),
        .raddr (addr),
        .rdata (mdl_rdata)
    );

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (in_clear) begin
            clr_ptr_d = clr_ptr_q + ADDR_ONE;
            if (clr_ptr_q == '1) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        pipe_vld_d     = '0;
        pipe_vld_d[0]  = run_rd;
        pipe_addr_d[0] = addr;
        pipe_exp_d[0]  = mdl_rdata;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
            pipe_exp_d[i]  = pipe_exp_q[i-1];
        end
    end

    always_comb begin
        pass_cnt_d  = pass_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        err_d       = err_q;
        err_addr_d  = err_addr_q;
        err_exp_d   = err_exp_q;
        err_act_d   = err_act_q;
        proto_err_d = proto_err_q | proto_hit;
        if (chk_vld) begin
            if (chk_match) begin
                if (pass_cnt_q != '1) begin
                    pass_cnt_d = pass_cnt_q + CNT_ONE;
                end
            end else begin
                if (fail_cnt_q != '1) begin
                    fail_cnt_d = fail_cnt_q + CNT_ONE;
                end
                err_d = 1'b1;
                if (!err_q) begin
                    err_addr_d = pipe_addr_q[RD_LAT-1];
                    err_exp_d  = pipe_exp_q[RD_LAT-1];
                    err_act_d  = dout;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            pass_cnt_q  <= '0;
            fail_cnt_q  <= '0;
            err_q       <= 1'b0;
            err_addr_q  <= '0;
            err_exp_q   <= '0;
            err_act_q   <= '0;
            proto_err_q <= 1'b0;
            pipe_vld_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            pass_cnt_q  <= pass_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            err_q       <= err_d;
            err_addr_q  <= err_addr_d;
            err_exp_q   <= err_exp_d;
            err_act_q   <= err_act_d;
            proto_err_q <= proto_err_d;
            pipe_vld_q  <= pipe_vld_d;
        end
    end

    // Payload stages need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        pipe_addr_q <= pipe_addr_d;
        pipe_exp_q  <= pipe_exp_d;
    end

    assign busy      = in_clear;
    assign pass_cnt  = pass_cnt_q;
    assign fail_cnt  = fail_cnt_q;
    assign err       = err_q;
    assign err_addr  = err_addr_q;
    assign err_exp   = err_exp_q;
    assign err_act   = err_act_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_scoreboard.sv
// Self-checking bench for mem_scoreboard. The bench plays the DUT memory:
// it drives dout RD_LAT cycles after each read, and a queue of issued reads
// predicts counter and first-error capture behaviour as compares complete.
module tb_mem_scoreboard;

    localparam int unsigned DW   = 8;
    localparam int unsigned AW   = 12;
    localparam int unsigned LAT  = 2;
    localparam int unsigned CW   = 3;
    localparam int unsigned CMAX = (1 << CW) - 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b1;
    logic          wr  = 1'b0;
    logic          rd  = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din  = '0;
    logic [DW-1:0] dout = '0;
    logic          busy;
    logic [CW-1:0] pass_cnt;
    logic [CW-1:0] fail_cnt;
    logic          err;
    logic [AW-1:0] err_addr;
    logic [DW-1:0] err_exp;
    logic [DW-1:0] err_act;
    logic          proto_err;

    mem_scoreboard #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .RD_LAT (LAT),
        .CNT_W  (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .wr        (wr),
        .rd        (rd),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .busy      (busy),
        .pass_cnt  (pass_cnt),
        .fail_cnt  (fail_cnt),
        .err       (err),
        .err_addr  (err_addr),
        .err_exp   (err_exp),
        .err_act   (err_act),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] expd;
        logic [DW-1:0] act;
        int unsigned   due;
    } rd_t;

    rd_t           rd_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] sched_val [16];
    int unsigned   cyc_n = 0;
    int            n_checks = 0;
    int            n_errors = 0;

    int unsigned   m_pass = 0;
    int unsigned   m_fail = 0;
    logic          m_err  = 1'b0;
    logic [AW-1:0] m_eaddr = '0;
    logic [DW-1:0] m_eexp  = '0;
    logic [DW-1:0] m_eact  = '0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, expv, cyc_n);
        end
    endtask

    task automatic check_status();
        check_eq("pass_cnt", 32'(pass_cnt), m_pass);
        check_eq("fail_cnt", 32'(fail_cnt), m_fail);
        check_eq("err", 32'(err), 32'(m_err));
        check_eq("err_addr", 32'(err_addr), 32'(m_eaddr));
        check_eq("err_exp", 32'(err_exp), 32'(m_eexp));
        check_eq("err_act", 32'(err_act), 32'(m_eact));
    endtask

    // One clock edge; afterwards present this cycle's dout and retire any
    // reads whose compare edge has just passed.
    task automatic step();
        rd_t e;
        bit  popped;
        @(posedge clk);
        #1;
        cyc_n++;
        dout   = sched_val[cyc_n % 16];
        popped = 1'b0;
        while (rd_q.size() > 0 && rd_q[0].due < cyc_n) begin
            e = rd_q.pop_front();
            popped = 1'b1;
            if (e.act == e.expd) begin
                if (m_pass != CMAX) m_pass++;
            end else begin
                if (m_fail != CMAX) m_fail++;
                if (!m_err) begin
                    m_err   = 1'b1;
                    m_eaddr = e.a;
                    m_eexp  = e.expd;
                    m_eact  = e.act;
                end
            end
        end
        if (popped) check_status();
    endtask

    task automatic do_idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            cen = 1'b1; wr = 1'b0; rd = 1'b0;
            step();
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cen = 1'b0; wr = 1'b1; rd = 1'b0; addr = a; din = d;
        step();
        ref_mem[a] = d;
        cen = 1'b1; wr = 1'b0;
    endtask

    // Read of address a; the bench answers with act as the DUT data.
    task automatic do_read_act(input logic [AW-1:0] a, input logic [DW-1:0] act);
        rd_t e;
        e.a    = a;
        e.expd = ref_mem[a];
        e.act  = act;
        e.due  = cyc_n + LAT;
        rd_q.push_back(e);
        sched_val[(cyc_n + LAT) % 16] = act;
        cen = 1'b0; wr = 1'b0; rd = 1'b1; addr = a;
        step();
        cen = 1'b1; rd = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        do_read_act(a, ref_mem[a]);
    endtask

    task automatic do_reset();
        cen = 1'b1; wr = 1'b0; rd = 1'b0;
        rst = 1'b1;
        rd_q.delete();
        step();
        rst = 1'b0;
        m_pass = 0; m_fail = 0; m_err = 1'b0;
        m_eaddr = '0; m_eexp = '0; m_eact = '0;
        for (int unsigned i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        check_eq("rst_busy", 32'(busy), 32'd1);
        check_eq("rst_proto_err", 32'(proto_err), 32'd0);
        check_status();
    endtask

    task automatic wait_sweep();
        int unsigned n;
        n = 0;
        while (busy === 1'b1 && n < 5000) begin
            do_idle(1);
            n++;
        end
        check_eq("busy_cycles", n, DEPTH);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) sched_val[i] = 8'h5A;

        // Reset sweep, then a read of a cleared location.
        do_reset();
        wait_sweep();
        do_read(12'h7FF);
        do_idle(3);
        check_eq("proto_err_idle", 32'(proto_err), 32'd0);

        // Write then read back.
        do_write(12'h403, 8'hA5);
        do_read(12'h403);
        do_idle(3);

        // Back-to-back reads; the write lands on the third read's compare cycle.
        do_write(12'h000, 8'h11);
        do_write(12'h001, 8'h22);
        do_write(12'h002, 8'h33);
        do_read(12'h000);
        do_read(12'h001);
        do_read(12'h002);
        do_idle(1);
        do_write(12'h001, 8'h99);
        do_read(12'h001);
        do_idle(3);

        // Illegal rd+wr: no model update, no check issued.
        sched_val[(cyc_n + LAT) % 16] = 8'hEE;
        cen = 1'b0; rd = 1'b1; wr = 1'b1; addr = 12'h010; din = 8'hFF;
        step();
        cen = 1'b1; rd = 1'b0; wr = 1'b0;
        do_idle(3);
        check_eq("proto_err_rdwr", 32'(proto_err), 32'd1);
        check_status();
        do_read(12'h010);
        do_idle(3);

        // Two mismatches; only the first is captured.
        do_write(12'hC10, 8'h3C);
        do_read_act(12'hC10, 8'h3D);
        do_read_act(12'h001, 8'h98);
        do_idle(4);
        check_eq("fail_two", 32'(fail_cnt), 32'd2);
        check_eq("err_addr_first", 32'(err_addr), 32'hC10);

        // Saturation of both counters.
        for (int i = 0; i < 9; i++) do_read(12'h403);
        for (int i = 0; i < 9; i++) do_read_act(12'h002, 8'h00);
        do_idle(4);
        check_eq("pass_sat", 32'(pass_cnt), CMAX);
        check_eq("fail_sat", 32'(fail_cnt), CMAX);

        // Reset with two reads outstanding, then reset again mid-sweep.
        do_read(12'h7FF);
        do_read(12'h403);
        do_reset();
        cen = 1'b0; rd = 1'b1; addr = 12'h020;
        step();
        cen = 1'b1; rd = 1'b0;
        check_eq("proto_err_clear", 32'(proto_err), 32'd1);
        do_idle(2046);
        check_eq("mid_busy", 32'(busy), 32'd1);
        check_status();
        do_reset();
        wait_sweep();
        check_status();
        do_read(12'h403);
        do_read(12'hC10);
        do_idle(4);
        check_eq("post_sweep_pass", 32'(pass_cnt), 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
